// File: rtl/multi_fifo_ram.sv
// multi_fifo_ram
//   Multi-lane FIFO built on a directly addressable entry array. Up to N_ENQ
//   entries can be enqueued and N_DEQ entries dequeued per cycle, in lane
//   order. Independent random-access read and write ports operate on the
//   same array. The tail can be flushed back to the head or rolled back to
//   a previously captured tail counter.
//
// Ports
//   clk                 sole clock, rising edge
//   rst_aL              synchronous active-low reset
//   enq_valid/enq_data  per-lane enqueue request and payload
//   enq_ready/enq_addr  lane i ready when free slots > i; slot it would fill
//   deq_valid/deq_ready lane i valid when count > i; per-lane acceptance
//   deq_data/deq_addr   entry and slot at (head+i) mod N_ENTRIES
//   rd_addr/rd_data     asynchronous random read ports
//   wr_en/wr_addr/wr_data random write ports (applied after enqueue writes)
//   flush               empty the queue (tail <= head + dequeued)
//   rollback_valid/ctr  restore the tail counter
//   count/full/empty    occupancy status
//   head_ctr/tail_ctr   raw wrap-around counters (one extra bit)
module multi_fifo_ram #(
    parameter int  ENTRY_WIDTH   = 32,
    parameter int  N_ENTRIES     = 16,
    parameter int  N_ENQ         = 2,
    parameter int  N_DEQ         = 2,
    parameter int  N_READ_PORTS  = 2,
    parameter int  N_WRITE_PORTS = 2,
    localparam int PTR_WIDTH     = $clog2(N_ENTRIES),
    localparam int CTR_WIDTH     = PTR_WIDTH + 1
) (
    input  logic                                       clk,
    input  logic                                       rst_aL,
    input  logic [N_ENQ-1:0]                           enq_valid,
    input  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]          enq_data,
    output logic [N_ENQ-1:0]                           enq_ready,
    output logic [N_ENQ-1:0][PTR_WIDTH-1:0]            enq_addr,
    output logic [N_DEQ-1:0]                           deq_valid,
    input  logic [N_DEQ-1:0]                           deq_ready,
    output logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]          deq_data,
    output logic [N_DEQ-1:0][PTR_WIDTH-1:0]            deq_addr,
    input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]     rd_addr,
    output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]   rd_data,
    input  logic [N_WRITE_PORTS-1:0]                   wr_en,
    input  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr,
    input  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]  wr_data,
    input  logic                                       flush,
    input  logic                                       rollback_valid,
    input  logic [CTR_WIDTH-1:0]                       rollback_ctr,
    output logic [CTR_WIDTH-1:0]                       count,
    output logic                                       full,
    output logic                                       empty,
    output logic [CTR_WIDTH-1:0]                       head_ctr,
    output logic [CTR_WIDTH-1:0]                       tail_ctr
);

    logic [CTR_WIDTH-1:0]   r_head_ctr;
    logic [CTR_WIDTH-1:0]   r_tail_ctr;
    logic [ENTRY_WIDTH-1:0] r_mem [N_ENTRIES];

    logic [CTR_WIDTH-1:0]   w_count;
    logic [CTR_WIDTH-1:0]   w_free;
    logic [CTR_WIDTH-1:0]   w_enq_n;
    logic [CTR_WIDTH-1:0]   w_deq_n;
    logic [CTR_WIDTH-1:0]   w_head_next;
    logic [PTR_WIDTH-1:0]   w_head_ptr;
    logic [PTR_WIDTH-1:0]   w_tail_ptr;
    logic                   w_enq_run;
    logic                   w_deq_run;

    // The extra counter bit distinguishes full from empty when the pointer
    // bits match; the subtraction wraps naturally.
    assign w_count     = r_tail_ctr - r_head_ctr;
    assign w_free      = CTR_WIDTH'(N_ENTRIES) - w_count;
    assign w_head_ptr  = r_head_ctr[PTR_WIDTH-1:0];
    assign w_tail_ptr  = r_tail_ctr[PTR_WIDTH-1:0];
    assign w_head_next = r_head_ctr + w_deq_n;

    assign count    = w_count;
    assign full     = (w_count == CTR_WIDTH'(N_ENTRIES));
    assign empty    = (w_count == '0);
    assign head_ctr = r_head_ctr;
    assign tail_ctr = r_tail_ctr;

    // Readiness comes from registered occupancy only, so a dequeue in the
    // same cycle never frees a slot for an enqueue.
    always_comb begin
        for (int i = 0; i < N_ENQ; i++) begin
            enq_ready[i] = (w_free > CTR_WIDTH'(i));
            enq_addr[i]  = w_tail_ptr + PTR_WIDTH'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < N_DEQ; i++) begin
            deq_valid[i] = (w_count > CTR_WIDTH'(i));
            deq_addr[i]  = w_head_ptr + PTR_WIDTH'(i);
            deq_data[i]  = r_mem[w_head_ptr + PTR_WIDTH'(i)];
        end
    end

    always_comb begin
        for (int r = 0; r < N_READ_PORTS; r++) begin
            rd_data[r] = r_mem[rd_addr[r]];
        end
    end

    // Accepted lanes form a prefix: the first lane that is not both valid
    // and ready stops the count, even if later lanes are valid.
    always_comb begin
        w_enq_n   = '0;
        w_enq_run = 1'b1;
        for (int i = 0; i < N_ENQ; i++) begin
            if (w_enq_run && enq_valid[i] && enq_ready[i]) begin
                w_enq_n = w_enq_n + CTR_WIDTH'(1);
            end else begin
                w_enq_run = 1'b0;
            end
        end
    end

    always_comb begin
        w_deq_n   = '0;
        w_deq_run = 1'b1;
        for (int i = 0; i < N_DEQ; i++) begin
            if (w_deq_run && deq_valid[i] && deq_ready[i]) begin
                w_deq_n = w_deq_n + CTR_WIDTH'(1);
            end else begin
                w_deq_run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            r_head_ctr <= '0;
            r_tail_ctr <= '0;
            for (int k = 0; k < N_ENTRIES; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            r_head_ctr <= w_head_next;
            if (flush) begin
                r_tail_ctr <= w_head_next;
            end else if (rollback_valid) begin
                // Legality of rollback_ctr is the caller's responsibility.
                r_tail_ctr <= rollback_ctr;
            end else begin
                r_tail_ctr <= r_tail_ctr + w_enq_n;
                for (int i = 0; i < N_ENQ; i++) begin
                    if (CTR_WIDTH'(i) < w_enq_n) begin
                        r_mem[w_tail_ptr + PTR_WIDTH'(i)] <= enq_data[i];
                    end
                end
            end
            // Later non-blocking writes override earlier ones, so random
            // writes beat enqueue writes and the highest port index wins.
            for (int w = 0; w < N_WRITE_PORTS; w++) begin
                if (wr_en[w]) begin
                    r_mem[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_fifo_ram.sv
module tb_multi_fifo_ram;

    logic              clk = 1'b0;
    logic              rst_aL;
    logic [1:0]        enq_valid;
    logic [1:0][31:0]  enq_data;
    logic [1:0]        enq_ready;
    logic [1:0][3:0]   enq_addr;
    logic [1:0]        deq_valid;
    logic [1:0]        deq_ready;
    logic [1:0][31:0]  deq_data;
    logic [1:0][3:0]   deq_addr;
    logic [1:0][3:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        wr_en;
    logic [1:0][3:0]   wr_addr;
    logic [1:0][31:0]  wr_data;
    logic              flush;
    logic              rollback_valid;
    logic [4:0]        rollback_ctr;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic [4:0]        head_ctr;
    logic [4:0]        tail_ctr;

    int checks   = 0;
    int failures = 0;

    // Reference model: counters as plain integers mod 32, slots as an array.
    int          m_head;
    int          m_tail;
    logic [31:0] m_mem [16];

    always #5 clk = ~clk;

    multi_fifo_ram dut (
        .clk(clk), .rst_aL(rst_aL),
        .enq_valid(enq_valid), .enq_data(enq_data),
        .enq_ready(enq_ready), .enq_addr(enq_addr),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_data(deq_data), .deq_addr(deq_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .rollback_valid(rollback_valid), .rollback_ctr(rollback_ctr),
        .count(count), .full(full), .empty(empty),
        .head_ctr(head_ctr), .tail_ctr(tail_ctr)
    );

    task automatic idle();
        rst_aL         = 1'b1;
        enq_valid      = '0;
        enq_data       = '0;
        deq_ready      = '0;
        wr_en          = '0;
        wr_addr        = '0;
        wr_data        = '0;
        flush          = 1'b0;
        rollback_valid = 1'b0;
        rollback_ctr   = '0;
    endtask

    // Advance one clock; the model computes its next state from the current
    // inputs using the queue rules, then outputs are sampled 1 time unit later.
    task automatic cycle();
        int          cnt, e, d, nh, nt;
        logic [31:0] nmem [16];
        cnt  = (m_tail - m_head) & 31;
        e = 0;
        while (e < 2 && enq_valid[e] && (16 - cnt) > e) e++;
        d = 0;
        while (d < 2 && deq_ready[d] && cnt > d) d++;
        nmem = m_mem;
        nh   = m_head;
        nt   = m_tail;
        if (!rst_aL) begin
            nh = 0;
            nt = 0;
            foreach (nmem[k]) nmem[k] = '0;
        end else begin
            nh = (m_head + d) & 31;
            if (flush) begin
                nt = nh;
            end else if (rollback_valid) begin
                checks++;
                if (((int'(rollback_ctr) - nh) & 31) > ((m_tail - nh) & 31)) begin
                    failures++;
                    $display("FAIL rollback_legality got=%0d exp=range %0d..%0d", rollback_ctr, nh, m_tail);
                end
                nt = int'(rollback_ctr);
            end else begin
                for (int i = 0; i < e; i++) nmem[(m_tail + i) & 15] = enq_data[i];
                nt = (m_tail + e) & 31;
            end
            for (int w = 0; w < 2; w++) if (wr_en[w]) nmem[wr_addr[w]] = wr_data[w];
        end
        @(posedge clk);
        m_head = nh;
        m_tail = nt;
        m_mem  = nmem;
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_aL = 1'b0;
        cycle();
        rst_aL = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_aL    = 1'b0;
        enq_valid = 2'b11;
        enq_data  = {32'hDEAD_0001, 32'hDEAD_0000};
        deq_ready = 2'b11;
        wr_en     = 2'b11;
        wr_addr   = {4'd7, 4'd3};
        wr_data   = {32'hBAD0_0002, 32'hBAD0_0001};
        flush     = 1'b1;
        cycle();
        idle();
        rd_addr = {4'd7, 4'd3};
        #1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=10", empty, full); end
        checks++; if (enq_ready !== 2'b11) begin failures++; $display("FAIL reset_enq_ready got=%b exp=11", enq_ready); end
        checks++; if (deq_valid !== 2'b00) begin failures++; $display("FAIL reset_deq_valid got=%b exp=00", deq_valid); end
        checks++; if (enq_addr !== {4'd1, 4'd0}) begin failures++; $display("FAIL reset_enq_addr got=%h exp=10", enq_addr); end
        checks++; if (deq_addr !== {4'd1, 4'd0}) begin failures++; $display("FAIL reset_deq_addr got=%h exp=10", deq_addr); end
        checks++; if (head_ctr !== 5'd0 || tail_ctr !== 5'd0) begin failures++; $display("FAIL reset_ctrs got=%0d/%0d exp=0/0", head_ctr, tail_ctr); end
        checks++; if (rd_data !== 64'd0) begin failures++; $display("FAIL reset_writes_discarded got=%h exp=0", rd_data); end
        // Reset in the middle of activity discards everything of that cycle.
        enq_valid = 2'b11;
        enq_data  = {32'h1111_0001, 32'h1111_0000};
        cycle();
        idle();
        rst_aL         = 1'b0;
        enq_valid      = 2'b11;
        deq_ready      = 2'b01;
        rollback_valid = 1'b1;
        rollback_ctr   = 5'd1;
        wr_en          = 2'b01;
        wr_addr        = {4'd0, 4'd9};
        wr_data        = {32'h0, 32'h5555_5555};
        cycle();
        idle();
        rd_addr = {4'd9, 4'd0};
        #1;
        checks++; if (count !== 5'd0 || tail_ctr !== 5'd0) begin failures++; $display("FAIL midop_reset_ctrs got=%0d/%0d exp=0/0", count, tail_ctr); end
        checks++; if (rd_data !== 64'd0) begin failures++; $display("FAIL midop_reset_mem got=%h exp=0", rd_data); end
    endtask

    task automatic test_dual_enqueue();
        apply_reset();
        enq_valid = 2'b11;
        enq_data  = {32'hBBBB_0002, 32'hAAAA_0001};
        cycle();
        idle();
        checks++; if (count !== 5'd2) begin failures++; $display("FAIL dual_enq_count got=%0d exp=2", count); end
        checks++; if (deq_data[0] !== 32'hAAAA_0001) begin failures++; $display("FAIL dual_enq_deq0 got=%h exp=aaaa0001", deq_data[0]); end
        checks++; if (deq_data[1] !== 32'hBBBB_0002) begin failures++; $display("FAIL dual_enq_deq1 got=%h exp=bbbb0002", deq_data[1]); end
        checks++; if (deq_addr !== {4'd1, 4'd0}) begin failures++; $display("FAIL dual_enq_deq_addr got=%h exp=10", deq_addr); end
        checks++; if (tail_ctr !== 5'd2 || deq_valid !== 2'b11) begin failures++; $display("FAIL dual_enq_tail got=%0d/%b exp=2/11", tail_ctr, deq_valid); end
    endtask

    task automatic test_lane_gap();
        apply_reset();
        enq_valid = 2'b10;
        enq_data  = {32'hCCCC_0001, 32'h0};
        cycle();
        idle();
        checks++; if (count !== 5'd0 || empty !== 1'b1 || tail_ctr !== 5'd0) begin
            failures++; $display("FAIL lane_gap got=count%0d empty%b tail%0d exp=count0 empty1 tail0", count, empty, tail_ctr);
        end
    endtask

    task automatic test_full_boundary();
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            enq_valid = 2'b11;
            enq_data  = {32'h1000 + 2 * k + 1, 32'h1000 + 2 * k};
            cycle();
        end
        enq_valid = 2'b01;
        enq_data  = {32'h0, 32'h100E};
        cycle();
        idle();
        checks++; if (count !== 5'd15 || enq_ready !== 2'b01) begin failures++; $display("FAIL almost_full got=%0d/%b exp=15/01", count, enq_ready); end
        enq_valid = 2'b11;
        enq_data  = {32'hE000_0002, 32'hE000_0001};
        cycle();
        idle();
        rd_addr = {4'd0, 4'd15};
        #1;
        checks++; if (count !== 5'd16 || full !== 1'b1 || enq_ready !== 2'b00) begin
            failures++; $display("FAIL fill_to_full got=count%0d full%b rdy%b exp=count16 full1 rdy00", count, full, enq_ready);
        end
        checks++; if (rd_data[0] !== 32'hE000_0001 || tail_ctr !== 5'd16) begin failures++; $display("FAIL fill_lane0_only got=%h/%0d exp=e0000001/16", rd_data[0], tail_ctr); end
        // Full with a dequeue in flight: nothing may be enqueued this cycle.
        enq_valid = 2'b11;
        enq_data  = {32'hF000_0002, 32'hF000_0001};
        deq_ready = 2'b01;
        cycle();
        idle();
        checks++; if (count !== 5'd15 || head_ctr !== 5'd1 || tail_ctr !== 5'd16) begin
            failures++; $display("FAIL full_deq_no_enq got=count%0d head%0d tail%0d exp=count15 head1 tail16", count, head_ctr, tail_ctr);
        end
        checks++; if (rd_data[1] !== 32'h1000) begin failures++; $display("FAIL full_slot0_kept got=%h exp=1000", rd_data[1]); end
    endtask

    task automatic test_rollback();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            enq_valid = 2'b11;
            enq_data  = {$urandom, $urandom};
            cycle();
        end
        enq_valid = 2'b01;
        cycle();
        idle();
        deq_ready = 2'b11;
        cycle();
        deq_ready = 2'b01;
        cycle();
        idle();
        checks++; if (head_ctr !== 5'd3 || tail_ctr !== 5'd9) begin failures++; $display("FAIL rollback_setup got=%0d/%0d exp=3/9", head_ctr, tail_ctr); end
        rollback_valid = 1'b1;
        rollback_ctr   = 5'd5;
        deq_ready      = 2'b11;
        enq_valid      = 2'b11;
        enq_data       = {32'h7777_0002, 32'h7777_0001};
        cycle();
        idle();
        checks++; if (head_ctr !== 5'd5 || tail_ctr !== 5'd5 || empty !== 1'b1) begin
            failures++; $display("FAIL rollback_result got=head%0d tail%0d empty%b exp=head5 tail5 empty1", head_ctr, tail_ctr, empty);
        end
    endtask

    task automatic test_write_priority_flush();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            enq_valid = 2'b11;
            enq_data  = {32'h10 + 2 * k + 1, 32'h10 + 2 * k};
            cycle();
        end
        idle();
        rd_addr   = {4'd0, 4'd4};
        enq_valid = 2'b01;
        enq_data  = {32'h0, 32'h4444_0000};
        wr_en     = 2'b11;
        wr_addr   = {4'd4, 4'd4};
        wr_data   = {32'h9999_0001, 32'h8888_0000};
        cycle();
        idle();
        checks++; if (rd_data[0] !== 32'h9999_0001 || tail_ctr !== 5'd5) begin
            failures++; $display("FAIL wr_priority got=%h/%0d exp=99990001/5", rd_data[0], tail_ctr);
        end
        flush = 1'b1;
        cycle();
        idle();
        checks++; if (empty !== 1'b1 || count !== 5'd0 || tail_ctr !== 5'd0) begin
            failures++; $display("FAIL flush_empty got=empty%b count%0d tail%0d exp=empty1 count0 tail0", empty, count, tail_ctr);
        end
        checks++; if (rd_data[0] !== 32'h9999_0001 || rd_data[1] !== 32'h10) begin
            failures++; $display("FAIL flush_keeps_mem got=%h/%h exp=99990001/10", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic [31:0] q [$];
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            v         = $urandom;
            enq_valid = 2'b01;
            enq_data  = {32'h0, v};
            cycle();
            idle();
            checks++; if (count !== 5'd1 || empty !== 1'b0 || full !== 1'b0 || deq_data[0] !== v) begin
                failures++; $display("FAIL wrap_enq_%0d got=count%0d data%h exp=count1 data%h", k, count, deq_data[0], v);
            end
            deq_ready = 2'b01;
            cycle();
            idle();
            checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL wrap_deq_%0d got=empty%b count%0d exp=empty1 count0", k, empty, count); end
        end
        checks++; if (head_ctr !== 5'd8 || tail_ctr !== 5'd8) begin failures++; $display("FAIL wrap_ctrs got=%0d/%0d exp=8/8", head_ctr, tail_ctr); end
        for (int k = 0; k < 8; k++) begin
            enq_valid = 2'b11;
            enq_data  = {$urandom, $urandom};
            q.push_back(enq_data[0]);
            q.push_back(enq_data[1]);
            cycle();
        end
        idle();
        checks++; if (full !== 1'b1 || count !== 5'd16 || tail_ctr !== 5'd24) begin
            failures++; $display("FAIL wrap_full got=full%b count%0d tail%0d exp=full1 count16 tail24", full, count, tail_ctr);
        end
        for (int k = 0; k < 16 && q.size() > 0; k++) begin
            checks++; if (deq_data[0] !== q[0]) begin failures++; $display("FAIL wrap_order_%0d got=%h exp=%h", k, deq_data[0], q[0]); end
            void'(q.pop_front());
            deq_ready = 2'b01;
            cycle();
            idle();
        end
        checks++; if (empty !== 1'b1 || head_ctr !== 5'd24) begin failures++; $display("FAIL wrap_drain got=empty%b head%0d exp=empty1 head24", empty, head_ctr); end
    endtask

    task automatic test_random();
        int cnt, d;
        for (int n = 0; n < 500; n++) begin
            idle();
            rst_aL    = ($urandom_range(0, 63) != 0);
            enq_valid = 2'($urandom);
            enq_data  = {$urandom, $urandom};
            deq_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            wr_en     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            wr_addr   = 8'($urandom);
            wr_data   = {$urandom, $urandom};
            rd_addr   = 8'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            cnt = (m_tail - m_head) & 31;
            d = 0;
            while (d < 2 && deq_ready[d] && cnt > d) d++;
            rollback_valid = ($urandom_range(0, 11) == 0);
            rollback_ctr   = 5'((m_head + d + $urandom_range(0, cnt - d)) & 31);
            cycle();
            cnt = (m_tail - m_head) & 31;
            checks++; if (count !== 5'(cnt)) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, cnt); end
            checks++; if (head_ctr !== 5'(m_head) || tail_ctr !== 5'(m_tail)) begin
                failures++; $display("FAIL rnd_ctrs n=%0d got=%0d/%0d exp=%0d/%0d", n, head_ctr, tail_ctr, m_head, m_tail);
            end
            checks++; if (full !== (cnt == 16) || empty !== (cnt == 0)) begin failures++; $display("FAIL rnd_flags n=%0d got=%b%b cnt=%0d", n, full, empty, cnt); end
            for (int i = 0; i < 2; i++) begin
                checks++; if (enq_ready[i] !== ((16 - cnt) > i) || deq_valid[i] !== (cnt > i)) begin
                    failures++; $display("FAIL rnd_handshake n=%0d lane=%0d got=%b%b cnt=%0d", n, i, enq_ready[i], deq_valid[i], cnt);
                end
                checks++; if (enq_addr[i] !== 4'((m_tail + i) & 15) || deq_addr[i] !== 4'((m_head + i) & 15)) begin
                    failures++; $display("FAIL rnd_addr n=%0d lane=%0d got=%0d/%0d exp=%0d/%0d", n, i, enq_addr[i], deq_addr[i], (m_tail + i) & 15, (m_head + i) & 15);
                end
                checks++; if (deq_data[i] !== m_mem[(m_head + i) & 15]) begin
                    failures++; $display("FAIL rnd_deq_data n=%0d lane=%0d got=%h exp=%h", n, i, deq_data[i], m_mem[(m_head + i) & 15]);
                end
                checks++; if (rd_data[i] !== m_mem[rd_addr[i]]) begin
                    failures++; $display("FAIL rnd_rd_data n=%0d port=%0d got=%h exp=%h", n, i, rd_data[i], m_mem[rd_addr[i]]);
                end
            end
        end
    endtask

    initial begin
        m_head  = 0;
        m_tail  = 0;
        foreach (m_mem[k]) m_mem[k] = '0;
        rd_addr = '0;
        idle();
        test_reset();
        test_dual_enqueue();
        test_lane_gap();
        test_full_boundary();
        test_rollback();
        test_write_priority_flush();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
